// File: rtl/up_down_counter_param.sv
// up_down_counter_param: up/down counter over 0..MAX_VAL with clear, load, wrap/saturate and sticky overflow.
// Defining UP_DOWN_COUNTER_PRESCALE_EN adds a prescaler so that a step happens only every PRESCALE enabled cycles.
module up_down_counter_param #(
    parameter int               WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}},
    parameter int               SATURATE = 0,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 1) begin : g_bad_cfg
        $error("up_down_counter_param: WIDTH must be 1..32 and PRESCALE >= 1");
    end

    logic [WIDTH-1:0] count_q, count_d, up_nxt, dn_nxt;
    logic             ovf_q, ovf_d;
    logic             at_top, at_bot, step, presc_tc;

`ifdef UP_DOWN_COUNTER_PRESCALE_EN
    localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] presc_q, presc_d;
    assign presc_tc = presc_q == PW'(PRESCALE - 1);
    // clr/load discard any partial prescale interval
    always_comb presc_d = (clr || load) ? '0 : !enable ? presc_q : presc_tc ? '0 : presc_q + PW'(1);
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) presc_q <= '0;
        else          presc_q <= presc_d;
    end
`else
    assign presc_tc = 1'b1;
`endif

    assign at_top = count_q == MAX_VAL;
    assign at_bot = count_q == '0;
    assign step   = enable && !clr && !load && presc_tc;
    assign up_nxt = at_top ? (SATURATE != 0 ? MAX_VAL : '0) : count_q + WIDTH'(1);
    assign dn_nxt = at_bot ? (SATURATE != 0 ? '0 : MAX_VAL) : count_q - WIDTH'(1);

    always_comb begin
        count_d = clr ? '0 : load ? (load_val > MAX_VAL ? MAX_VAL : load_val) : step ? (up_down ? up_nxt : dn_nxt) : count_q;
        ovf_d   = clr ? 1'b0 : ovf_q | (step & (up_down ? at_top : at_bot));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    assign tc    = enable & ((up_down & at_top) | (~up_down & at_bot));

endmodule

// File: doc/up_down_counter_param.md
UP_DOWN_COUNTER_PARAM -- requirements
Module: up_down_counter_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 4: counter width in bits (1..32).
REQ-002 SHALL provide parameter MAX_VAL, default 2**WIDTH-1: terminal value of the count range 0..MAX_VAL.
REQ-003 SHALL provide parameter SATURATE, default 0: 0 = wrap at range ends, 1 = hold at range ends.
REQ-004 SHALL provide parameter PRESCALE, default 1: enabled cycles per count step (used only with the prescaler macro).
REQ-005 SHALL provide port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL provide port reset_n  input  1  asynchronous, active-low reset.
REQ-007 SHALL provide port enable  input  1  count-step qualifier.
REQ-008 SHALL provide port up_down  input  1  direction: 1 = up, 0 = down.
REQ-009 SHALL provide port clr  input  1  synchronous clear.
REQ-010 SHALL provide port load  input  1  synchronous parallel load.
REQ-011 SHALL provide port load_val  input  WIDTH  value for load.
REQ-012 SHALL provide port count  output  WIDTH  registered counter value.
REQ-013 SHALL provide port tc  output  1  combinational terminal-count flag.
REQ-014 SHALL provide port ovf  output  1  registered sticky over/underflow flag.

Function
REQ-015 SHALL apply per-edge priority: reset_n low > clr > load > step > hold.
REQ-016 clr=1 SHALL set count=0 and ovf=0 on the next edge.
REQ-017 load=1 (clr=0) SHALL set count=load_val, or count=MAX_VAL if load_val>MAX_VAL; ovf unchanged.
REQ-018 A step SHALL occur on an edge with enable=1, clr=0, load=0 (and prescaler terminal when compiled in).
REQ-019 An up step SHALL give count+1 when count<MAX_VAL; at count=MAX_VAL, count SHALL become 0 (SATURATE=0) or stay MAX_VAL (SATURATE=1).
REQ-020 A down step SHALL give count-1 when count>0; at count=0, count SHALL become MAX_VAL (SATURATE=0) or stay 0 (SATURATE=1).
REQ-021 Arithmetic SHALL be WIDTH bits, no wider intermediate exposed; count SHALL never exceed MAX_VAL.
REQ-022 tc SHALL equal enable & ((up_down & count==MAX_VAL) | (~up_down & count==0)), independent of the prescaler.
REQ-023 ovf SHALL set on any step taken at a range end (wrap or saturate) and SHALL stay set until clr or reset.
REQ-024 A direction change SHALL take effect on the same edge it is sampled; no extra latency.
REQ-025 enable=0 with clr=0 and load=0 SHALL hold count and ovf.

Reset
REQ-026 reset_n low SHALL immediately force count=0, ovf=0, prescaler state=0, regardless of clk.
REQ-027 Reset deassertion SHALL take effect on the first rising clk edge with reset_n high; in-progress prescale intervals SHALL be discarded.

Configuration
REQ-028 With macro UP_DOWN_COUNTER_PRESCALE_EN defined, an internal prescale counter SHALL count enabled cycles 0..PRESCALE-1 and a step SHALL occur only on the enabled edge where it equals PRESCALE-1, returning it to 0.
REQ-029 With the macro defined, clr or load SHALL reset the prescale counter to 0; enable=0 SHALL hold it.
REQ-030 Without the macro, no prescale logic SHALL exist, PRESCALE SHALL be ignored, and every enabled edge SHALL step.

Verification (WIDTH=4, MAX_VAL=9 unless noted)
REQ-031 Reset low mid-count at count=5 -> count=0, ovf=0 before next clk edge.
REQ-032 SATURATE=0, up, enable held 12 cycles from 0 -> count 1..9,0,1,2; tc=1 while count=9; ovf=1 from the wrap edge.
REQ-033 SATURATE=1, down from 2, enable 4 cycles -> count 1,0,0,0; ovf=1 after third step.
REQ-034 load=1, load_val=13 with enable=1 -> count=9; same edge clr=1 with load=1 -> count=0, ovf=0.
REQ-035 up_down toggled each cycle from count=4, enable=1 -> count 5,4,5,4.
REQ-036 Macro defined, PRESCALE=3, up, enable held 9 cycles from 0 -> count steps to 1,2,3 on enabled cycles 3,6,9 only.
